io_hub: RTL and testbench
=========================

# io_hub

Parametrised memory-mapped I/O hub between the 6502 core bus and board peripherals. It replaces fixed inline address decoding with a relocatable register window. It buffers PS/2 scancodes in a DEPTH-entry FIFO instead of a single latch, and holds a multi-bit video mode register. An optional level interrupt request signals pending keyboard data. Addresses outside the window pass memory read data through unchanged.

## Interface
- BASE, 16'h0200, start of 4-byte register window; must be 4-byte aligned
- DEPTH, 16, scancode FIFO entries; power of two, 2..32
- MODE_W, 2, width of the video mode register, 1..8

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  16  CPU address
- din  in  8  CPU write data
- we  in  1  CPU write strobe, sampled on the rising clock edge
- mem_q  in  8  read data from main memory
- dout  out  8  read data to CPU (combinational)
- sel  out  1  high when address is inside BASE..BASE+3 (combinational)
- ps2_data  in  8  received scancode
- ps2_hit  in  1  one-cycle strobe: ps2_data valid
- mode  out  MODE_W  video mode register
- irq  out  1  interrupt request, active high

## Operation
- Register map, offsets from BASE:
  - +0 R: FIFO head byte (peek); 8'h00 when empty. W: any value pops one entry.
  - +1 R: status {nonempty, overflow, count[5:0]}. W: bit7=1 flushes the FIFO; bit6=1 clears overflow.
  - +2 R/W: mode in bits [MODE_W-1:0]; reads return zeros in the upper bits.
  - +3 R/W: bit0 = irq_en (IO_IRQ_EN only); otherwise reads 8'h00 and writes are ignored.
- Outside the window, dout = mem_q. sel goes to the top level so it can gate memory writes.
- FIFO: circular buffer with read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
  - Push on ps2_hit when not full.
  - Push when full: the byte is dropped and overflow is set (sticky).
  - Pop when empty: ignored, no state change.
  - Push and pop in the same cycle:
    - Both act when nonempty, including when full; count is unchanged.
    - When empty, only the push takes effect.
  - Flush in the same cycle as a push: flush wins, the pushed byte is discarded, and count becomes 0.
  - Clear-overflow in the same cycle as an overflowing push: overflow stays set.
- Reset (asynchronous, any time, including mid-push): pointers, count and overflow = 0, mode = 0, irq_en = 0, irq = 0. FIFO storage contents are don't-care.

## Timing
- Register writes take effect on the rising edge where we=1; the new value is visible on dout in the next cycle.
- A byte pushed at edge N is readable at +0 from cycle N+1. Status count updates at the same edge.
- A pop at edge N exposes the next entry from cycle N+1.
- dout and sel are purely combinational from address, registers and mem_q, with zero wait states.
- irq is registered: it asserts one cycle after the edge where the FIFO becomes nonempty (with irq_en=1). It deasserts one cycle after the edge where the FIFO becomes empty or irq_en is cleared.

## Configuration
- IO_IRQ_EN defined: irq_en register at +3 and irq = registered (irq_en & nonempty).
- IO_IRQ_EN undefined: no irq_en flop; irq tied to 0; +3 reads 8'h00 and ignores writes.

## Test plan
- Reset: assert reset_n=0 mid-run → mode=0, status read 8'h00, irq=0, +0 read 8'h00; address 16'h1234 returns mem_q.
- Push 8'h1C, 8'h32, 8'h21 → status 8'h83; +0 reads 8'h1C, then pop → 8'h32, pop → 8'h21, pop → status 8'h00; a further pop leaves status 8'h00.
- DEPTH=16: push 17 bytes 8'h01..8'h11 → status 8'hD0; head 8'h01; 8'h11 lost. Write +1 = 8'h40 → status 8'h90.
- Full FIFO with simultaneous ps2_hit (8'hAA) and pop → count stays 16; after 15 pops, head = 8'hAA. Flush plus push in the same cycle → status 8'h00.
- Write +2 = 8'hFF with MODE_W=2 → mode=2'b11, read back 8'h03. A write to BASE-1 leaves mode unchanged and sel=0.
- IO_IRQ_EN: write +3 = 8'h01, push 8'h5A → irq high after 1 cycle; pop → irq low after 1 cycle. Without the macro, irq stays 0 throughout.

Source files
------------

// File: rtl/io_hub.sv
// Memory-mapped I/O hub: relocatable 4-byte register window, PS/2 scancode FIFO and video mode register.
// Optional keyboard interrupt (irq_en register at +3, registered irq) is built when IO_IRQ_EN is defined.
module io_hub #(
    parameter logic [15:0] BASE   = 16'h0200,
    parameter int          DEPTH  = 16,
    parameter int          MODE_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       address,
    input  logic [7:0]        din,
    input  logic              we,
    input  logic [7:0]        mem_q,
    output logic [7:0]        dout,
    output logic              sel,
    input  logic [7:0]        ps2_data,
    input  logic              ps2_hit,
    output logic [MODE_W-1:0] mode,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Register offsets within the window.
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_MODE   = 2'd2;
    localparam logic [1:0] OFS_IRQ    = 2'd3;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic [1:0]    offset;
    logic          reg_wr;
    logic          pop_req;
    logic          flush;
    logic          clr_ovf;
    logic          empty;
    logic          full;
    logic          nonempty;
    logic          do_pop;
    logic          do_push;
    logic          ovf_set;
    logic [7:0]    head;
    logic [7:0]    status;
    logic [7:0]    mode_rd;
    logic [7:0]    irq_rd;
    logic          unused_din;

    // Window decode: BASE is 4-byte aligned, so the top 14 address bits select the window.
    assign sel    = (address[15:2] == BASE[15:2]);
    assign offset = address[1:0];
    assign reg_wr = we & sel;

    assign pop_req = reg_wr && (offset == OFS_DATA);
    assign flush   = reg_wr && (offset == OFS_STATUS) && din[7];
    assign clr_ovf = reg_wr && (offset == OFS_STATUS) && din[6];

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign nonempty = ~empty;

    // ps2_hit is a one-cycle valid strobe with no ready/backpressure: a push the FIFO
    // cannot accept is dropped and recorded in the sticky overflow flag.
    // A pop frees a slot in the same cycle, so a full FIFO can accept push+pop together.
    assign do_pop  = pop_req & nonempty & ~flush;
    assign do_push = ps2_hit & ~flush & (~full | do_pop);
    assign ovf_set = ps2_hit & ~flush & full & ~do_pop;

    always_ff @(posedge clock) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= ps2_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A dropped push in the same cycle as clear-overflow keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode <= '0;
        end else if (reg_wr && (offset == OFS_MODE)) begin
            mode <= din[MODE_W-1:0];
        end
    end

`ifdef IO_IRQ_EN
    logic irq_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (reg_wr && (offset == OFS_IRQ)) begin
                irq_en <= din[0];
            end
            irq <= irq_en & nonempty;
        end
    end

    assign irq_rd = {7'b0, irq_en};
`else
    assign irq    = 1'b0;
    assign irq_rd = 8'h00;
`endif

    assign head   = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign status = {nonempty, overflow, 6'(count)};

    always_comb begin
        mode_rd = '0;
        mode_rd[MODE_W-1:0] = mode;
    end

    always_comb begin
        dout = mem_q;
        if (sel) begin
            case (offset)
                OFS_DATA:   dout = head;
                OFS_STATUS: dout = status;
                OFS_MODE:   dout = mode_rd;
                default:    dout = irq_rd;
            endcase
        end
    end

    // Only a few data bits carry meaning per register; the rest are intentionally ignored.
    assign unused_din = &{1'b0, din};

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: directed register-map scenarios plus a randomised push/pop phase
// checked against a reference FIFO model; irq expectations follow IO_IRQ_EN.
module tb_io_hub;

    localparam logic [15:0] BASE   = 16'h0200;
    localparam int          DEPTH  = 16;
    localparam int          MODE_W = 2;
`ifdef IO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic              clock;
    logic              reset_n;
    logic [15:0]       address;
    logic [7:0]        din;
    logic              we;
    logic [7:0]        mem_q;
    logic [7:0]        dout;
    logic              sel;
    logic [7:0]        ps2_data;
    logic              ps2_hit;
    logic [MODE_W-1:0] mode;
    logic              irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_q[$];
    logic       m_ovf;

    io_hub #(
        .BASE   (BASE),
        .DEPTH  (DEPTH),
        .MODE_W (MODE_W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .address  (address),
        .din      (din),
        .we       (we),
        .mem_q    (mem_q),
        .dout     (dout),
        .sel      (sel),
        .ps2_data (ps2_data),
        .ps2_hit  (ps2_hit),
        .mode     (mode),
        .irq      (irq)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {m_q.size() > 0, m_ovf, 6'(m_q.size())};
    endfunction

    function automatic logic [7:0] model_head();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // One bus cycle: inputs set after a falling edge, held across one rising edge.
    task automatic drive(input logic hit, input logic [7:0] data, input logic wen,
                         input logic [15:0] a, input logic [7:0] d);
        logic pop_ok;
        logic push_ok;
        logic flush;
        logic clr;
        @(negedge clock);
        ps2_hit  = hit;
        ps2_data = data;
        we       = wen;
        address  = a;
        din      = d;
        flush = wen && (a == BASE + 16'd1) && d[7];
        clr   = wen && (a == BASE + 16'd1) && d[6];
        if (flush) begin
            m_q.delete();
            if (clr) m_ovf = 1'b0;
        end else begin
            pop_ok  = wen && (a == BASE) && (m_q.size() > 0);
            push_ok = hit && ((m_q.size() < DEPTH) || pop_ok);
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(data);
            if (hit && !push_ok) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(negedge clock);
        ps2_hit = 1'b0;
        we      = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic pop();
        drive(1'b0, 8'h00, 1'b1, BASE, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        drive(1'b0, 8'h00, 1'b1, a, d);
    endtask

    // Read through the scoreboard; mem_q is randomised so in-window reads cannot leak it.
    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        address = a;
        mem_q   = 8'($urandom_range(0, 255));
        exp_q.push_back(exp);
        #1;
        check(tag, dout, exp_q.pop_front());
    endtask

    task automatic rd_mem(input string tag, input logic [15:0] a);
        logic [7:0] v;
        v       = 8'($urandom_range(0, 255));
        address = a;
        mem_q   = v;
        exp_q.push_back(v);
        #1;
        check(tag, dout, exp_q.pop_front());
    endtask

    initial begin
        reset_n  = 1'b0;
        address  = 16'h0000;
        din      = 8'h00;
        we       = 1'b0;
        mem_q    = 8'h00;
        ps2_data = 8'h00;
        ps2_hit  = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // reset asserted mid-run
        push(8'h44);
        push(8'h45);
        wr(BASE + 16'd2, 8'hFF);
        check("pre_reset_mode", 8'(mode), 8'h03);
        @(negedge clock);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_mode", 8'(mode), 8'h00);
        check("reset_irq", 8'(irq), 8'h00);
        rd("reset_status", BASE + 16'd1, 8'h00);
        rd("reset_head", BASE, 8'h00);
        rd_mem("reset_mem", 16'h1234);
        @(negedge clock);
        reset_n = 1'b1;

        // basic push / peek / pop
        push(8'h1C);
        push(8'h32);
        push(8'h21);
        rd("status_3", BASE + 16'd1, 8'h83);
        rd("head_1c", BASE, 8'h1C);
        check("sel_in", 8'(sel), 8'h01);
        pop();
        rd("head_32", BASE, 8'h32);
        pop();
        rd("head_21", BASE, 8'h21);
        pop();
        rd("status_empty", BASE + 16'd1, 8'h00);
        rd("head_empty", BASE, 8'h00);
        pop();
        rd("status_pop_empty", BASE + 16'd1, 8'h00);

        // overflow
        for (int i = 1; i <= 17; i++) push(8'(i));
        rd("status_ovf", BASE + 16'd1, 8'hD0);
        rd("head_ovf", BASE, 8'h01);
        wr(BASE + 16'd1, 8'h40);
        rd("status_clr", BASE + 16'd1, 8'h90);

        // full with simultaneous push and pop
        drive(1'b1, 8'hAA, 1'b1, BASE, 8'h00);
        rd("status_full_pp", BASE + 16'd1, 8'h90);
        for (int i = 0; i < 15; i++) begin
            rd("head_drain", BASE, model_head());
            pop();
        end
        rd("head_aa", BASE, 8'hAA);
        rd("status_one", BASE + 16'd1, 8'h81);
        drive(1'b1, 8'h77, 1'b1, BASE + 16'd1, 8'h80);
        rd("status_flush_push", BASE + 16'd1, 8'h00);
        rd("head_flush_push", BASE, 8'h00);

        // mode register and window edge
        wr(BASE + 16'd2, 8'hFF);
        check("mode_ff", 8'(mode), 8'h03);
        rd("mode_rd", BASE + 16'd2, 8'h03);
        wr(BASE - 16'd1, 8'h00);
        check("mode_keep", 8'(mode), 8'h03);
        address = BASE - 16'd1;
        #1;
        check("sel_below", 8'(sel), 8'h00);
        rd_mem("mem_below", BASE - 16'd1);
        address = BASE + 16'd4;
        #1;
        check("sel_above", 8'(sel), 8'h00);
        wr(BASE + 16'd2, 8'h01);
        rd("mode_01", BASE + 16'd2, 8'h01);

        // interrupt request
        wr(BASE + 16'd3, 8'h01);
        rd("irq_en_rd", BASE + 16'd3, IRQ_ON ? 8'h01 : 8'h00);
        check("irq_idle", 8'(irq), 8'h00);
        push(8'h5A);
        check("irq_lat0", 8'(irq), 8'h00);
        @(negedge clock);
        check("irq_set", 8'(irq), 8'(IRQ_ON));
        pop();
        check("irq_hold", 8'(irq), 8'(IRQ_ON));
        @(negedge clock);
        check("irq_clr", 8'(irq), 8'h00);
        push(8'h11);
        wr(BASE + 16'd3, 8'h00);
        check("irq_en_off_lat", 8'(irq), 8'(IRQ_ON));
        @(negedge clock);
        check("irq_en_off", 8'(irq), 8'h00);

        // random push/pop mix against the model
        wr(BASE + 16'd1, 8'hC0);
        for (int i = 0; i < 80; i++) begin
            logic hit;
            logic p;
            hit = (i < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            p   = (i < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(hit, 8'($urandom_range(0, 255)), p, p ? BASE : 16'h0000, 8'h00);
            rd("rnd_status", BASE + 16'd1, model_status());
            rd("rnd_head", BASE, model_head());
            if (i == 39) begin
                wr(BASE + 16'd1, 8'h40);
                rd("rnd_clr", BASE + 16'd1, model_status());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
